// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard
//   ID-stage operand forwarding and RAW-hazard unit. It keeps a registered
//   shadow of the destination writes in flight in the back-end stages. For
//   each source operand it picks the youngest in-flight producer of that
//   register. It forwards that stage's result, or it flags a stall when the
//   result is produced too late to be forwarded this cycle.
//
// Ports
//   clk, resetn        clock; asynchronous active-low reset
//   id_valid           ID holds a valid instruction
//   id_rs              source register addresses, operand i at [i*AW +: AW]
//   id_rs_used         per-operand "actually read" mask
//   id_wr_en           ID instruction writes a register
//   id_wr_addr         destination register of the ID instruction
//   id_avail_stage     first stage index at which its result is valid
//   id_go              ID instruction enters EX this cycle
//   adv                back-end pipeline advances this cycle
//   flush              kill the youngest FLUSH_DEPTH stages and the issuing op
//   rf_rdata           register-file read data per operand
//   stage_wdata        result currently held by each stage
//   rd_data            forwarded operand data
//   fwd_src            one-hot source per operand (bit0 = regfile, k+1 = stage k)
//   raw_stall          ID must hold
//   stall_cycles       saturating count of stalled cycles
module fwd_scoreboard #(
  parameter int NUM_RD      = 2,
  parameter int NUM_STAGES  = 3,
  parameter int DATA_W      = 32,
  parameter int AW          = 5,
  parameter int SW          = 2,
  parameter int FLUSH_DEPTH = 1
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           id_valid,
  input  logic [NUM_RD*AW-1:0]           id_rs,
  input  logic [NUM_RD-1:0]              id_rs_used,
  input  logic                           id_wr_en,
  input  logic [AW-1:0]                  id_wr_addr,
  input  logic [SW-1:0]                  id_avail_stage,
  input  logic                           id_go,
  input  logic                           adv,
  input  logic                           flush,
  input  logic [NUM_RD*DATA_W-1:0]       rf_rdata,
  input  logic [NUM_STAGES*DATA_W-1:0]   stage_wdata,
  output logic [NUM_RD*DATA_W-1:0]       rd_data,
  output logic [NUM_RD*(NUM_STAGES+1)-1:0] fwd_src,
  output logic                           raw_stall,
  output logic [31:0]                    stall_cycles
);

  localparam int SRCW = NUM_STAGES + 1;

  // In-flight write shadow, one entry per back-end stage (0 = youngest).
  logic [NUM_STAGES-1:0] valid_reg, valid_next;
  logic [NUM_STAGES-1:0] wr_en_reg, wr_en_next;
  logic [AW-1:0]         addr_reg  [NUM_STAGES];
  logic [AW-1:0]         addr_next [NUM_STAGES];
  logic [SW-1:0]         avail_reg [NUM_STAGES];
  logic [SW-1:0]         avail_next[NUM_STAGES];
  logic [31:0]           stall_cnt_reg, stall_cnt_next;

  logic [NUM_RD-1:0]     hazard;
  logic                  iss;

  // ---------------------------------------------------------------------
  // Per-operand match, priority select and data mux
  // ---------------------------------------------------------------------
  genvar gi, gk;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_op
      logic [AW-1:0]         rs;
      logic [NUM_STAGES-1:0] match;
      logic                  hit;
      logic                  rdy;
      logic [SRCW-1:0]       src;
      logic [DATA_W-1:0]     data;

      assign rs = id_rs[gi*AW +: AW];

      // r0 is hardwired, so a write to it never forwards.
      for (gk = 0; gk < NUM_STAGES; gk++) begin : g_match
        assign match[gk] = valid_reg[gk] & wr_en_reg[gk] &
                           (addr_reg[gk] == rs) & (rs != '0);
      end

      // Scan from oldest to youngest so the youngest match overrides.
      // An older ready match never overrides a younger unready match.
      always_comb begin
        hit  = 1'b0;
        rdy  = 1'b0;
        src  = '0;
        src[0] = 1'b1;
        data = rf_rdata[gi*DATA_W +: DATA_W];
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
          if (match[k]) begin
            hit    = 1'b1;
            rdy    = (int'(avail_reg[k]) <= k);
            src    = '0;
            src[k+1] = 1'b1;
            data   = stage_wdata[k*DATA_W +: DATA_W];
          end
        end
      end

      assign hazard[gi] = hit & ~rdy & id_rs_used[gi];
      assign fwd_src[gi*SRCW +: SRCW]     = src;
      assign rd_data[gi*DATA_W +: DATA_W] = data;
    end
  endgenerate

  assign raw_stall    = id_valid & (|hazard);
  // A go request during a stall or flush becomes a bubble.
  assign iss          = id_valid & id_go & ~raw_stall & ~flush;
  assign stall_cycles = stall_cnt_reg;

  // ---------------------------------------------------------------------
  // Shadow update: the flush kill applies before the shift, so the flushed
  // young entries move down as bubbles when adv is also set.
  // ---------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      valid_next[k] = valid_reg[k] & ~(flush & (k < FLUSH_DEPTH));
      wr_en_next[k] = wr_en_reg[k];
      addr_next[k]  = addr_reg[k];
      avail_next[k] = avail_reg[k];
    end
    if (adv) begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        valid_next[k] = valid_reg[k-1] & ~(flush & ((k - 1) < FLUSH_DEPTH));
        wr_en_next[k] = wr_en_reg[k-1];
        addr_next[k]  = addr_reg[k-1];
        avail_next[k] = avail_reg[k-1];
      end
      valid_next[0] = iss;
      wr_en_next[0] = id_wr_en;
      addr_next[0]  = id_wr_addr;
      avail_next[0] = id_avail_stage;
    end
  end

  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (raw_stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_next = stall_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_reg     <= '0;
      wr_en_reg     <= '0;
      stall_cnt_reg <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        addr_reg[k]  <= '0;
        avail_reg[k] <= '0;
      end
    end else begin
      valid_reg     <= valid_next;
      wr_en_reg     <= wr_en_next;
      stall_cnt_reg <= stall_cnt_next;
      for (int k = 0; k < NUM_STAGES; k++) begin
        addr_reg[k]  <= addr_next[k];
        avail_reg[k] <= avail_next[k];
      end
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard
//   Directed bench for fwd_scoreboard. The stimulus process queues the
//   hand-computed expected outputs for each cycle. A monitor compares them
//   against the DUT on the falling edge.
module tb_fwd_scoreboard;

  localparam logic [31:0] R0 = 32'h1111_1111;
  localparam logic [31:0] R1 = 32'h2222_2222;
  localparam logic [31:0] S0 = 32'hDEAD_BEEF;
  localparam logic [31:0] S1 = 32'hB0B0_0001;
  localparam logic [31:0] S2 = 32'hC0C0_0002;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic        id_wr_en;
  logic [4:0]  id_wr_addr;
  logic [1:0]  id_avail_stage;
  logic        id_go;
  logic        adv;
  logic        flush;
  logic [63:0] rf_rdata;
  logic [95:0] stage_wdata;
  logic [63:0] rd_data;
  logic [7:0]  fwd_src;
  logic        raw_stall;
  logic [31:0] stall_cycles;

  fwd_scoreboard dut (
    .clk(clk), .resetn(resetn), .id_valid(id_valid), .id_rs(id_rs),
    .id_rs_used(id_rs_used), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
    .id_avail_stage(id_avail_stage), .id_go(id_go), .adv(adv), .flush(flush),
    .rf_rdata(rf_rdata), .stage_wdata(stage_wdata), .rd_data(rd_data),
    .fwd_src(fwd_src), .raw_stall(raw_stall), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  src;
    logic [63:0] data;
    logic [1:0]  dmask;
    logic        stall;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  // Issuing into a frozen back-end is a protocol error.
  always @(posedge clk) begin
    if (resetn === 1'b1)
      assert (!(id_go && !adv)) else $error("protocol: id_go asserted without adv");
  end

  // Monitor: compares every queued expectation against the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        chk_cnt++;
        if (fwd_src === e.src) pass_cnt++;
        else $display("FAIL %s fwd_src got %h want %h", e.name, fwd_src, e.src);
        chk_cnt++;
        if (raw_stall === e.stall) pass_cnt++;
        else $display("FAIL %s raw_stall got %b want %b", e.name, raw_stall, e.stall);
        chk_cnt++;
        if (stall_cycles === e.cnt) pass_cnt++;
        else $display("FAIL %s stall_cycles got %h want %h", e.name, stall_cycles, e.cnt);
        for (int l = 0; l < 2; l++) begin
          if (e.dmask[l]) begin
            chk_cnt++;
            if (rd_data[l*32 +: 32] === e.data[l*32 +: 32]) pass_cnt++;
            else $display("FAIL %s rd_data[%0d] got %h want %h", e.name, l,
                          rd_data[l*32 +: 32], e.data[l*32 +: 32]);
          end
        end
        $display("txn %-10s src=%h stall=%b cnt=%h data=%h", e.name, fwd_src,
                 raw_stall, stall_cycles, rd_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs0,
                       input logic [1:0] used, input logic we, input logic [4:0] wa,
                       input logic [1:0] av, input logic go, input logic a,
                       input logic fl);
    id_valid       = v;
    id_rs          = {rs1, rs0};
    id_rs_used     = used;
    id_wr_en       = we;
    id_wr_addr     = wa;
    id_avail_stage = av;
    id_go          = go;
    adv            = a;
    flush          = fl;
  endtask

  task automatic cyc(input logic v, input logic [4:0] rs1, input logic [4:0] rs0,
                     input logic [1:0] used, input logic we, input logic [4:0] wa,
                     input logic [1:0] av, input logic go, input logic a,
                     input logic fl);
    tick();
    drive(v, rs1, rs0, used, we, wa, av, go, a, fl);
  endtask

  task automatic ex(input string name, input logic [7:0] src, input logic [63:0] data,
                    input logic [1:0] dmask, input logic stall, input logic [31:0] cnt);
    exp_t e;
    e.name = name; e.src = src; e.data = data; e.dmask = dmask;
    e.stall = stall; e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic drain();
    repeat (3) cyc(0, 5'd4, 5'd3, 2'b00, 0, 5'd0, 2'd0, 0, 1, 0);
  endtask

  initial begin
    rf_rdata    = {R1, R0};
    stage_wdata = {S2, S1, S0};
    drive(1, 5'd4, 5'd3, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0);
    resetn = 1'b1;
    #1 resetn = 1'b0;
    ex("rst_hold", 8'h11, {R1, R0}, 2'b11, 0, 32'd0);
    tick();
    resetn = 1'b1;

    // Idle after reset
    cyc(1, 5'd4, 5'd3, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0);
    ex("idle", 8'h11, {R1, R0}, 2'b11, 0, 32'd0);
    // ALU r5 forwarded from EX
    cyc(1, 5'd4, 5'd3, 2'b11, 1, 5'd5, 2'd0, 1, 1, 0);
    ex("alu_iss", 8'h11, {R1, R0}, 2'b11, 0, 32'd0);
    cyc(1, 5'd4, 5'd5, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0);
    ex("alu_fwd", 8'h12, {R1, S0}, 2'b11, 0, 32'd0);
    drain();

    // Load-use on r7
    cyc(1, 5'd4, 5'd3, 2'b11, 1, 5'd7, 2'd1, 1, 1, 0);
    ex("ld_iss", 8'h11, {R1, R0}, 2'b11, 0, 32'd0);
    cyc(1, 5'd7, 5'd3, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0);
    ex("ld_use", 8'h21, {32'h0, R0}, 2'b01, 1, 32'd0);
    cyc(1, 5'd7, 5'd3, 2'b11, 0, 5'd0, 2'd0, 0, 1, 0);
    ex("ld_use2", 8'h21, {32'h0, R0}, 2'b01, 1, 32'd1);
    cyc(1, 5'd7, 5'd3, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0);
    ex("ld_ready", 8'h41, {S1, R0}, 2'b11, 0, 32'd2);
    drain();

    // r9: unready load in EX shadows a ready ALU write in WB
    cyc(1, 5'd4, 5'd3, 2'b11, 1, 5'd9, 2'd0, 1, 1, 0);
    cyc(1, 5'd4, 5'd3, 2'b11, 0, 5'd0, 2'd0, 0, 1, 0);
    cyc(1, 5'd4, 5'd3, 2'b11, 1, 5'd9, 2'd1, 1, 1, 0);
    cyc(1, 5'd3, 5'd9, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0);
    ex("r9_young", 8'h12, {R1, 32'h0}, 2'b10, 1, 32'd2);
    cyc(1, 5'd3, 5'd9, 2'b10, 0, 5'd0, 2'd0, 0, 0, 0);
    ex("r9_unused", 8'h12, {R1, 32'h0}, 2'b10, 0, 32'd3);
    drain();

    // r0 never forwards; unused operands never stall
    cyc(1, 5'd4, 5'd3, 2'b11, 1, 5'd0, 2'd0, 1, 1, 0);
    cyc(1, 5'd0, 5'd0, 2'b11, 1, 5'd2, 2'd1, 1, 1, 0);
    ex("r0_read", 8'h11, {R1, R0}, 2'b11, 0, 32'd3);
    cyc(1, 5'd2, 5'd2, 2'b00, 0, 5'd0, 2'd0, 0, 0, 0);
    ex("r2_unused", 8'h22, 64'h0, 2'b00, 0, 32'd3);
    cyc(1, 5'd2, 5'd2, 2'b01, 0, 5'd0, 2'd0, 0, 0, 0);
    ex("r2_used", 8'h22, 64'h0, 2'b00, 1, 32'd3);
    cyc(0, 5'd2, 5'd2, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0);
    ex("r2_idv0", 8'h22, 64'h0, 2'b00, 0, 32'd4);
    drain();

    // Flush of the youngest stage
    cyc(1, 5'd4, 5'd3, 2'b11, 1, 5'd6, 2'd1, 1, 1, 0);
    cyc(1, 5'd4, 5'd6, 2'b11, 0, 5'd0, 2'd0, 0, 1, 1);
    ex("fl_stall", 8'h12, {R1, 32'h0}, 2'b10, 1, 32'd4);
    cyc(1, 5'd4, 5'd6, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0);
    ex("fl_gone", 8'h11, {R1, R0}, 2'b11, 0, 32'd5);
    cyc(1, 5'd4, 5'd3, 2'b11, 1, 5'd8, 2'd0, 1, 1, 1);
    ex("fl_iss", 8'h11, {R1, R0}, 2'b11, 0, 32'd5);
    cyc(1, 5'd8, 5'd3, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0);
    ex("fl_noiss", 8'h11, {R1, R0}, 2'b11, 0, 32'd5);
    // Entry older than FLUSH_DEPTH survives the flush
    cyc(1, 5'd4, 5'd3, 2'b11, 1, 5'd6, 2'd1, 1, 1, 0);
    cyc(0, 5'd4, 5'd3, 2'b11, 0, 5'd0, 2'd0, 0, 1, 0);
    cyc(1, 5'd4, 5'd6, 2'b11, 0, 5'd0, 2'd0, 0, 1, 1);
    ex("fl_old", 8'h14, {R1, S1}, 2'b11, 0, 32'd5);
    cyc(1, 5'd4, 5'd6, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0);
    ex("fl_keep", 8'h18, {R1, S2}, 2'b11, 0, 32'd5);
    drain();

    // Counter saturation
    cyc(1, 5'd4, 5'd3, 2'b11, 1, 5'd7, 2'd1, 1, 1, 0);
    tick();
    drive(1, 5'd7, 5'd3, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0);
    force dut.stall_cnt_reg = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt_reg;
    ex("sat0", 8'h21, {32'h0, R0}, 2'b01, 1, 32'hFFFF_FFFE);
    cyc(1, 5'd7, 5'd3, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0);
    ex("sat1", 8'h21, {32'h0, R0}, 2'b01, 1, 32'hFFFF_FFFF);
    cyc(1, 5'd7, 5'd3, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0);
    ex("sat2", 8'h21, {32'h0, R0}, 2'b01, 1, 32'hFFFF_FFFF);

    // Asynchronous reset mid-operation, together with flush
    tick();
    drive(1, 5'd7, 5'd3, 2'b11, 0, 5'd0, 2'd0, 0, 0, 1);
    resetn = 1'b0;
    #1 ex("rst_mid", 8'h11, {R1, R0}, 2'b11, 0, 32'd0);
    tick();
    resetn = 1'b1;
    drive(1, 5'd7, 5'd3, 2'b11, 0, 5'd0, 2'd0, 0, 0, 0);
    ex("rst_after", 8'h11, {R1, R0}, 2'b11, 0, 32'd0);

    // Give the monitor a bounded number of edges to drain the queue.
    for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time %0t want finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
